// File: rtl/arduino_cmd_rx.sv
// arduino_cmd_rx: 8N1 UART receiver for the Arduino command link.
// Turns received bytes into the registered drive command and manual-mode
// flag, rejects unknown drive codes, and forces stop on link silence or
// when manual mode is dropped.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on the synchronised rx
// S_START | half a bit into the start bit; a high sample means a glitch
// S_DATA  | sampling 8 data bits LSB first, one per bit period
// S_STOP  | sampling the stop bit; high accepts the byte, low is an error
module arduino_cmd_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int TIMEOUT_MS = 200
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       uart_rx_i,
  output logic [7:0] arduino_command_o,
  output logic       manual_on_o,
  output logic       cmd_valid_o,
  output logic       cmd_reject_o,
  output logic       frame_error_o,
  output logic       timeout_o
);

  localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD;
  localparam int HALF_BIT       = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CYCLES = (CLK_FREQ / 1000) * TIMEOUT_MS;
  localparam int TMR_W          = $clog2(CLKS_PER_BIT + 1);
  localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF_BIT - 1);
  localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;

  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic rx_fall;

  logic byte_ok, stop_bad;

  logic [7:0]      cmd_q, cmd_d;
  logic            manual_q, manual_d;
  logic            valid_q, valid_d;
  logic            reject_q, reject_d;
  logic            ferr_q, ferr_d;
  logic            tmo_q, tmo_d;
  logic [WD_W-1:0] wd_q, wd_d;

  function automatic logic is_drive_code(input logic [7:0] b);
    case (b)
      8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
      8'h08, 8'h09, 8'h0A, 8'h0C: is_drive_code = 1'b1;
      default:                    is_drive_code = 1'b0;
    endcase
  endfunction

  // Two-flop synchroniser plus previous-value flop for edge detection; idle high.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s_q;

  // RX FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: IDLE re-arms on the stop sample so a back-to-back start edge is caught.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        if (rx_fall) state_d = S_START;
      end
      S_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stop-bit sample strobes for an accepted byte or a framing error.
  always_comb begin
    byte_ok  = 1'b0;
    stop_bad = 1'b0;
    if (state_q == S_STOP && timer_q == BIT_LAST) begin
      byte_ok  = rx_s_q;
      stop_bad = ~rx_s_q;
    end
  end

  // Byte classification and watchdog; an accepted drive byte overrides expiry.
  always_comb begin
    cmd_d    = cmd_q;
    manual_d = manual_q;
    valid_d  = 1'b0;
    reject_d = 1'b0;
    ferr_d   = stop_bad;
    tmo_d    = tmo_q;
    wd_d     = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

    if (wd_q == WD_LAST) begin
      cmd_d = 8'h00;
      tmo_d = 1'b1;
    end

    if (byte_ok) begin
      if (shift_q[7]) begin
        manual_d = shift_q[0];
        if (manual_q && !shift_q[0]) cmd_d = 8'h00;
      end else if (is_drive_code(shift_q)) begin
        cmd_d   = shift_q;
        valid_d = 1'b1;
        wd_d    = '0;
        tmo_d   = 1'b0;
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  // Registered outputs and watchdog counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_q    <= 8'h00;
      manual_q <= 1'b0;
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
      ferr_q   <= 1'b0;
      tmo_q    <= 1'b1;
      wd_q     <= '0;
    end else begin
      cmd_q    <= cmd_d;
      manual_q <= manual_d;
      valid_q  <= valid_d;
      reject_q <= reject_d;
      ferr_q   <= ferr_d;
      tmo_q    <= tmo_d;
      wd_q     <= wd_d;
    end
  end

  assign arduino_command_o = cmd_q;
  assign manual_on_o       = manual_q;
  assign cmd_valid_o       = valid_q;
  assign cmd_reject_o      = reject_q;
  assign frame_error_o     = ferr_q;
  assign timeout_o         = tmo_q;

endmodule

// File: doc/arduino_cmd_rx.md
# arduino_cmd_rx

Receives the Arduino's 8N1 UART byte stream and turns it into the registered `arduino_command` byte and `manual_on` flag consumed by the manual-mode direction FSM. Validates drive codes and separates mode bytes from drive bytes. Forces the command to stop (0x00) when the link goes silent or manual mode is dropped. Sits between the board UART RX pin and `manual_mode`.

## Interface
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD, 9600: UART bit rate.
- TIMEOUT_MS, 200: command watchdog period in ms.
- Derived: CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide); TIMEOUT_CYCLES = (CLK_FREQ/1000)*TIMEOUT_MS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- uart_rx  in  1  raw asynchronous serial line, idle high.
- arduino_command  out  8  last accepted drive code; 0x00 = stop.
- manual_on  out  1  manual mode enable from the last mode byte.
- cmd_valid  out  1  one-cycle pulse when arduino_command is written by a received byte.
- cmd_reject  out  1  one-cycle pulse when a drive byte with an illegal code is dropped.
- frame_error  out  1  one-cycle pulse when the stop bit samples low.
- timeout  out  1  level; high while no valid drive byte has arrived within TIMEOUT_CYCLES.

## Operation
- **Input synchroniser:** two flops on uart_rx, both reset to 1. All RX logic uses the second stage (`rx_s`). An edge detector compares `rx_s` against its previous value.
- **RX FSM (IDLE, START, DATA, STOP):**
  - IDLE: a falling edge on `rx_s` moves to START and clears the bit timer.
  - START: after CLKS_PER_BIT/2 cycles, sample the line. If 0, go to DATA with the timer cleared. If 1, treat it as a glitch and return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first, into the shift register. After 8 bits, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. If 1, the byte is accepted. If 0, pulse frame_error and discard the byte. Either way, return to IDLE.
- **Byte classification** (applies to accepted bytes only):
  - bit7 = 1 is a mode byte: manual_on <= bit0. No cmd_valid pulse; the watchdog is unaffected.
  - bit7 = 0 with code in {0x00, 0x01, 0x02, 0x03, 0x04, 0x08, 0x09, 0x0A, 0x0C} is a drive byte: arduino_command <= byte, cmd_valid pulses, watchdog counter cleared, timeout <= 0.
  - bit7 = 0 with any other code: cmd_reject pulses. arduino_command, the watchdog and timeout are unchanged.
- **Watchdog:**
  - The counter increments every cycle and saturates at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES: arduino_command <= 0x00 and timeout <= 1. No cmd_valid pulse.
- **Manual drop:** a mode byte that takes manual_on from 1 to 0 also sets arduino_command <= 0x00 in the same update, with no cmd_valid pulse.
- **Simultaneous events:** an accepted drive byte in the same cycle as watchdog expiry wins; the command is written, the counter cleared and timeout stays 0.

## Timing
- **Reset values:**
  - arduino_command = 0x00, manual_on = 0, timeout = 1.
  - cmd_valid, cmd_reject and frame_error = 0.
  - FSM in IDLE; bit timer, bit index and watchdog counter at 0.
- **Latency:**
  - Outputs update on the clock edge after the stop-bit sample cycle.
  - The cmd_valid, cmd_reject and frame_error pulses are registered and high for exactly that one cycle, coincident with the new output value.
  - From the falling start edge at the pin to the output update: 2 synchroniser cycles, plus ≈9.5·CLKS_PER_BIT, plus 1 cycle.
- **Back-to-back frames:** a start bit immediately after a stop bit (no idle gap) must be received. IDLE is entered at the stop sample, mid-stop-bit, so the next falling edge is detected.
- **Frame error followed by a held-low line:** no new frame starts until a fresh falling edge is seen.
- **Reset mid-frame:** the partial byte is discarded, all outputs return to their reset values immediately (asynchronous), and reception resumes on the next falling edge after reset deasserts.
- **Watchdog timing:** timeout rises exactly TIMEOUT_CYCLES cycles after the cmd_valid cycle if no further drive byte arrives.

## Test plan
Bench parameters: CLK_FREQ = 1_000_000, BAUD = 100_000 (10 clks/bit), TIMEOUT_MS = 1 (1000 cycles).

1. Reset, then send 0x81 followed by 0x0A → manual_on = 1; arduino_command = 0x0A with a single-cycle cmd_valid; timeout falls to 0.
2. Send 0x05, then 0x7F → two cmd_reject pulses; arduino_command stays 0x0A; no cmd_valid.
3. Send 0x01 with the stop bit driven 0 → frame_error pulses once; arduino_command unchanged. A following good 0x02 is accepted.
4. After an accepted 0x08, stay idle → exactly 1000 cycles after cmd_valid, arduino_command = 0x00 and timeout = 1; no cmd_valid at that point.
5. Send 0x09 and 0x0C back-to-back with no idle gap → two cmd_valid pulses 100 cycles apart; final arduino_command = 0x0C. Then send 0x80 → manual_on = 0 and arduino_command = 0x00.
6. Apply a 3-cycle low glitch while idle → no output change. Assert reset during DATA of a frame → all outputs return to reset values; the next full frame 0x04 is received correctly.
